// File: rtl/sys_bus_reg_slave.sv
// Register-bank slave on the system bus: ID, scratch, sticky flags, control and status words.
// Optional error responses enabled by defining SYS_BUS_SLV_ERR_EN.
module sys_bus_reg_slave #(
  parameter int          ADDR_W      = 20,
  parameter int          NCTRL       = 4,
  parameter int          NSTAT       = 4,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5253_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     sys_addr,
  input  logic [31:0]           sys_wdata,
  input  logic                  sys_wen,
  input  logic                  sys_ren,
  output logic [31:0]           sys_rdata,
  output logic                  sys_err,
  output logic                  sys_ack,
  output logic [NCTRL*32-1:0]   ctrl_o,
  output logic [NCTRL-1:0]      ctrl_wr_o,
  input  logic [NSTAT*32-1:0]   stat_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [5:0] CTRL_END = 6'(4 + NCTRL);
  localparam logic [5:0] STAT_END = 6'(16 + NSTAT);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           flags_q, flags_d;
  logic [NCTRL*32-1:0]  ctrl_q, ctrl_d;
  logic [NCTRL-1:0]     ctrl_wr_q, ctrl_wr_d;
  logic                 err_q, err_d;

  logic [4:0]  word;
  logic        hi_ok, hit_id, hit_scr, hit_flg, hit_ctrl, hit_stat;
  logic [4:0]  ctrl_idx;
  logic [3:0]  stat_idx;
  logic [31:0] rd_val;
  logic        req;
  logic        unused_addr;

  assign unused_addr = ^sys_addr[1:0];
  assign word     = sys_addr[6:2];
  assign hi_ok    = (sys_addr[ADDR_W-1:7] == '0);
  assign hit_id   = hi_ok && (word == 5'd0);
  assign hit_scr  = hi_ok && (word == 5'd1);
  assign hit_flg  = hi_ok && (word == 5'd2);
  assign hit_ctrl = hi_ok && (word >= 5'd4) && ({1'b0, word} < CTRL_END);
  assign hit_stat = hi_ok && (word >= 5'd16) && ({1'b0, word} < STAT_END);
  assign ctrl_idx = word - 5'd4;
  assign stat_idx = word[3:0];
  assign req      = sys_wen | sys_ren;

`ifdef SYS_BUS_SLV_ERR_EN
  logic illegal;
  assign illegal = !(hit_id || hit_scr || hit_flg || hit_ctrl || hit_stat) ||
                   (sys_wen && (hit_id || hit_stat));
`endif

  always_comb begin
    rd_val = '0;
    if (hit_id)       rd_val = ID_VALUE;
    else if (hit_scr) rd_val = scratch_q;
    else if (hit_flg) rd_val = {30'b0, flags_q};
    else if (hit_ctrl) begin
      for (int i = 0; i < NCTRL; i++)
        if (ctrl_idx == 5'(i)) rd_val = ctrl_q[32*i +: 32];
    end else if (hit_stat) begin
      for (int j = 0; j < NSTAT; j++)
        if (stat_idx == 4'(j)) rd_val = stat_i[32*j +: 32];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scratch_d = scratch_q;
    flags_d   = flags_q;
    ctrl_d    = ctrl_q;
    ctrl_wr_d = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;

    // Any strobe while a transaction is in flight is dropped and flagged.
    if (req && (state_q != ST_IDLE)) flags_d[0] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
          cnt_d   = 4'(WAIT_STATES - 1);
          rdata_d = (sys_ren && !sys_wen) ? rd_val : '0;
`ifdef SYS_BUS_SLV_ERR_EN
          err_d = illegal;
          if (illegal) rdata_d = '0;
`else
          err_d = 1'b0;
`endif
          if (sys_wen) begin
            if (hit_scr) scratch_d = sys_wdata;
            if (hit_flg) flags_d = flags_q & ~sys_wdata[1:0];
            if (hit_ctrl) begin
              for (int i = 0; i < NCTRL; i++)
                if (ctrl_idx == 5'(i)) begin
                  ctrl_d[32*i +: 32] = sys_wdata;
                  ctrl_wr_d[i]       = 1'b1;
                end
            end
          end
          // Applied after the W1C so a coincident collision set wins.
          if (sys_wen && sys_ren) flags_d[1] = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      scratch_q <= '0;
      rdata_q   <= '0;
      flags_q   <= '0;
      ctrl_q    <= '0;
      ctrl_wr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      flags_q   <= flags_d;
      ctrl_q    <= ctrl_d;
      ctrl_wr_q <= ctrl_wr_d;
      err_q     <= err_d;
    end
  end

  assign sys_ack   = (state_q == ST_RESP);
  assign sys_err   = sys_ack & err_q;
  assign sys_rdata = rdata_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign ctrl_o    = ctrl_q;
  assign ctrl_wr_o = ctrl_wr_q;

endmodule

// File: tb/tb_sys_bus_reg_slave.sv
// Directed bench for sys_bus_reg_slave: one instance with no wait states, one with three.
module tb_sys_bus_reg_slave;
  localparam int AW = 20;
  localparam int NC = 4;
  localparam int NS = 4;
`ifdef SYS_BUS_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   addr;
  logic [31:0]     wdata;
  logic            wen0, ren0, wen3, ren3;
  logic [NS*32-1:0] stat;

  logic [31:0]     rdata0, rdata3;
  logic            err0, err3, ack0, ack3, busy0, busy3;
  logic [NC*32-1:0] ctrl0, ctrl3;
  logic [NC-1:0]   ctrl_wr0, ctrl_wr3;

  always #5 clk = ~clk;

  sys_bus_reg_slave #(.ADDR_W(AW), .NCTRL(NC), .NSTAT(NS), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .sys_addr(addr), .sys_wdata(wdata),
    .sys_wen(wen0), .sys_ren(ren0), .sys_rdata(rdata0), .sys_err(err0),
    .sys_ack(ack0), .ctrl_o(ctrl0), .ctrl_wr_o(ctrl_wr0), .stat_i(stat), .busy_o(busy0));

  sys_bus_reg_slave #(.ADDR_W(AW), .NCTRL(NC), .NSTAT(NS), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .sys_addr(addr), .sys_wdata(wdata),
    .sys_wen(wen3), .sys_ren(ren3), .sys_rdata(rdata3), .sys_err(err3),
    .sys_ack(ack3), .ctrl_o(ctrl3), .ctrl_wr_o(ctrl_wr3), .stat_i(stat), .busy_o(busy3));

  typedef struct {
    bit          inst;
    bit          w;
    bit          r;
    logic [19:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ackof(input bit inst);
    return inst ? ack3 : ack0;
  endfunction

  // Present a strobe so it is sampled at the next rising edge; returns 1ns after that edge.
  task automatic drive(input bit inst, input bit w, input bit r,
                       input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    if (inst) begin wen3 = w; ren3 = r; end
    else      begin wen0 = w; ren0 = r; end
    @(posedge clk);
    #1;
    wen0 = 1'b0; ren0 = 1'b0; wen3 = 1'b0; ren3 = 1'b0;
  endtask

  task automatic wait_ack(input bit inst, output int lat);
    lat = 1;
    while (!ackof(inst) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ackof(inst)) lat = 99;
  endtask

  task automatic txn(input bit inst, input bit w, input bit r, input logic [19:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic er,
                     output int lat);
    drive(inst, w, r, a, d);
    wait_ack(inst, lat);
    rd = inst ? rdata3 : rdata0;
    er = inst ? err3 : err0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acks;

    addr = '0; wdata = '0; wen0 = 0; ren0 = 0; wen3 = 0; ren3 = 0;
    stat = {32'h5354_0003, 32'h5354_0002, 32'h5354_0001, 32'h5354_0000};

    tbl.push_back('{1'b0, 1'b1, 1'b0, 20'h00004, 32'hA5A5_0001, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00004, 32'h0,         32'hA5A5_0001, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00000, 32'h0,         32'h5253_0001, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 20'h00010, 32'h1234_5678, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00010, 32'h0,         32'h1234_5678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 20'h0001C, 32'hDEAD_BEEF, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h0001C, 32'h0,         32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00048, 32'h0,         32'h5354_0002, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h0004C, 32'h0,         32'h5354_0003, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h0000C, 32'h0,         32'h0,          ERR_EN});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 20'h00040, 32'hFFFF_FFFF, 32'h0,          ERR_EN});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00040, 32'h0,         32'h5354_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 20'h00000, 32'h0000_0BAD, 32'h0,          ERR_EN});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00000, 32'h0,         32'h5253_0001, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00020, 32'h0,         32'h0,          ERR_EN});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00050, 32'h0,         32'h0,          ERR_EN});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00080, 32'h0,         32'h0,          ERR_EN});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 20'h00084, 32'h1111_1111, 32'h0,          ERR_EN});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00004, 32'h0,         32'hA5A5_0001, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 20'h00008, 32'h0,         32'h0,          1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 20'h00000, 32'h0,         32'h5253_0001, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 20'h00004, 32'h0BAD_F00D, 32'h0,          1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 20'h00004, 32'h0,         32'h0BAD_F00D, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 20'h0000C, 32'h0,         32'h0,          ERR_EN});

    // Reset state
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.ack0", 32'(ack0), 0);       chk("rst.ack3", 32'(ack3), 0);
    chk("rst.err0", 32'(err0), 0);       chk("rst.rdata3", rdata3, 0);
    chk("rst.busy0", 32'(busy0), 0);     chk("rst.busy3", 32'(busy3), 0);
    chk("rst.ctrl_wr3", 32'(ctrl_wr3), 0);
    chk("rst.ctrl0", 32'(ctrl0 != '0), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      txn(tbl[i].inst, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, rd, er, lat);
      chk($sformatf("v%0d.lat", i), 32'(lat), tbl[i].inst ? 32'd4 : 32'd1);
      chk($sformatf("v%0d.rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("v%0d.err", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // Control write with three wait states: strobe in T+1 only, ack in T+4
    chk("A.pre_ctrl1", ctrl3[63:32], 32'h0);
    drive(1'b1, 1'b1, 1'b0, 20'h00014, 32'h0000_00FF);
    chk("A.t1_ctrl1", ctrl3[63:32], 32'h0000_00FF);
    chk("A.t1_wr", 32'(ctrl_wr3), 32'h2);
    chk("A.t1_ack", 32'(ack3), 0);
    chk("A.t1_busy", 32'(busy3), 1);
    @(posedge clk); #1;
    chk("A.t2_wr", 32'(ctrl_wr3), 0);
    chk("A.t2_ack", 32'(ack3), 0);
    @(posedge clk); #1;
    chk("A.t3_ack", 32'(ack3), 0);
    @(posedge clk); #1;
    chk("A.t4_ack", 32'(ack3), 1);
    chk("A.t4_err", 32'(err3), 0);
    @(posedge clk); #1;
    chk("A.t5_ack", 32'(ack3), 0);
    chk("A.t5_busy", 32'(busy3), 0);

    // Status captured at the accept edge, not at ack
    drive(1'b1, 1'b0, 1'b1, 20'h00044, 32'h0);
    stat[63:32] = 32'hCAFE_0001;
    wait_ack(1'b1, lat);
    chk("B.lat", 32'(lat), 4);
    chk("B.rdata", rdata3, 32'h5354_0001);
    @(posedge clk); #1;
    stat[63:32] = 32'h5354_0001;

    // Request during WAIT: dropped, single ack, OVERRUN set then cleared by W1C
    drive(1'b1, 1'b0, 1'b1, 20'h00000, 32'h0);
    acks = int'(ack3);
    drive(1'b1, 1'b0, 1'b1, 20'h00004, 32'h0);
    acks += int'(ack3);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      acks += int'(ack3);
    end
    chk("C.acks", 32'(acks), 1);
    txn(1'b1, 1'b0, 1'b1, 20'h00008, 32'h0, rd, er, lat);
    chk("C.flags_set", rd, 32'h1);
    txn(1'b1, 1'b1, 1'b0, 20'h00008, 32'h1, rd, er, lat);
    txn(1'b1, 1'b0, 1'b1, 20'h00008, 32'h0, rd, er, lat);
    chk("C.flags_clr", rd, 32'h0);

    // Simultaneous write and read: write done, one ack, COLLISION set; set beats W1C
    drive(1'b0, 1'b1, 1'b1, 20'h00004, 32'h5A5A_0002);
    acks = int'(ack0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      acks += int'(ack0);
    end
    chk("D.acks", 32'(acks), 1);
    txn(1'b0, 1'b0, 1'b1, 20'h00004, 32'h0, rd, er, lat);
    chk("D.scratch", rd, 32'h5A5A_0002);
    txn(1'b0, 1'b0, 1'b1, 20'h00008, 32'h0, rd, er, lat);
    chk("D.flags", rd, 32'h2);
    txn(1'b0, 1'b1, 1'b1, 20'h00008, 32'h3, rd, er, lat);
    txn(1'b0, 1'b0, 1'b1, 20'h00008, 32'h0, rd, er, lat);
    chk("D.set_wins", rd, 32'h2);

    // Reset during WAIT aborts the transaction
    drive(1'b1, 1'b0, 1'b1, 20'h00004, 32'h0);
    chk("E.busy_wait", 32'(busy3), 1);
    #2 rst = 1'b1;
    #1;
    chk("E.busy", 32'(busy3), 0);
    chk("E.ack", 32'(ack3), 0);
    chk("E.ctrl", 32'(ctrl3 != '0), 0);
    acks = 0;
    @(posedge clk); #1; acks += int'(ack3);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      acks += int'(ack3);
    end
    chk("E.no_ack", 32'(acks), 0);
    txn(1'b1, 1'b0, 1'b1, 20'h00004, 32'h0, rd, er, lat);
    chk("E.lat", 32'(lat), 4);
    chk("E.scratch", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
